// File: rtl/wb_sram_ctrl_pkg.sv
// Shared definitions for the Wishbone-to-async-SRAM controller:
// FSM state encoding, default wait states and SRAM geometry.
package wb_sram_ctrl_pkg;

  // SRAM geometry, shared with the sram256_16 model
  localparam int unsigned SRAM_AB_WIDTH = 18;
  localparam int unsigned SRAM_DW       = 16;
  localparam int unsigned SRAM_WORDS    = 1 << SRAM_AB_WIDTH;

  // Wait-state counter geometry and default strobe stretch
  localparam int unsigned WS_WIDTH      = 4;
  localparam int unsigned WS_DEFAULT    = 1;

  // Controller sequencing states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WSETUP = 3'd2,
    ST_WR     = 3'd3,
    ST_WHOLD  = 3'd4,
    ST_ACK    = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

endpackage

// File: rtl/wb_sram_ctrl_ws_counter.sv
// Wait-state down counter: parallel load, decrement, saturates at zero.
module sram_ws_counter
  import wb_sram_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WS_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load has priority; decrement stops at zero so the count never wraps
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave sequencing a 256k x 16 asynchronous SRAM.
// One bus cycle becomes chip select, output/write enable stretched by
// WAIT_STATES extra cycles, and a write hold cycle. All pins are registered.
module wb_sram_ctrl
  import wb_sram_ctrl_pkg::*;
#(
  parameter int unsigned AB_WIDTH    = SRAM_AB_WIDTH,
  parameter int unsigned ADR_WIDTH   = 24,
  parameter int unsigned WAIT_STATES = WS_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 CYC_I,
  input  logic                 STB_I,
  input  logic                 WE_I,
  input  logic [ADR_WIDTH-1:0] ADR_I,
  input  logic [1:0]           SEL_I,
  input  logic [15:0]          DAT_I,
  output logic [15:0]          DAT_O,
  output logic                 ACK_O,
  output logic                 ERR_O,
  output logic [AB_WIDTH-1:0]  sram_addr_o,
  output logic [15:0]          sram_dat_o,
  input  logic [15:0]          sram_dat_i,
  output logic [1:0]           sram_bsel_o,
  output logic                 sram_ncs_o,
  output logic                 sram_noe_o,
  output logic                 sram_nwe_o
);

  state_e state;
  logic   request;
  logic   out_of_range;
  logic   ws_load;
  logic   ws_dec;
  logic   ws_zero;

  assign request      = CYC_I & STB_I;
  // Any address bit above the SRAM word range marks the access as invalid
  assign out_of_range = |(ADR_I >> (AB_WIDTH + 1));

  // Counter is armed when the strobe phase starts: on read accept, and on the
  // setup-to-strobe transition for writes; it only counts during a strobe
  always_comb begin
    ws_load = 1'b0;
    ws_dec  = 1'b0;
    case (state)
      ST_IDLE:   ws_load = request & ~out_of_range & ~WE_I;
      ST_WSETUP: ws_load = 1'b1;
      ST_RD,
      ST_WR:     ws_dec  = 1'b1;
      default:   ;
    endcase
  end

  sram_ws_counter #(
    .WIDTH (WS_WIDTH)
  ) u_ws_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load       (ws_load),
    .load_value (WS_WIDTH'(WAIT_STATES)),
    .dec        (ws_dec),
    .zero       (ws_zero)
  );

  // Access sequencer with registered SRAM strobes and bus responses;
  // ACK_O is gated by CYC_I so an abandoned cycle finishes silently on the SRAM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      sram_ncs_o  <= 1'b1;
      sram_noe_o  <= 1'b1;
      sram_nwe_o  <= 1'b1;
      sram_addr_o <= '0;
      sram_dat_o  <= '0;
      sram_bsel_o <= '0;
      DAT_O       <= '0;
      ACK_O       <= 1'b0;
      ERR_O       <= 1'b0;
    end else begin
      ACK_O <= 1'b0;
      ERR_O <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (request) begin
            if (out_of_range) begin
              ERR_O <= 1'b1;
              state <= ST_ERR;
            end else begin
              sram_addr_o <= ADR_I[AB_WIDTH:1];
              sram_bsel_o <= SEL_I;
              sram_ncs_o  <= 1'b0;
              if (WE_I) begin
                sram_dat_o <= DAT_I;
                state      <= ST_WSETUP;
              end else begin
                sram_noe_o <= 1'b0;
                state      <= ST_RD;
              end
            end
          end
        end
        ST_RD: begin
          if (ws_zero) begin
            DAT_O      <= sram_dat_i;
            sram_ncs_o <= 1'b1;
            sram_noe_o <= 1'b1;
            ACK_O      <= CYC_I;
            state      <= ST_ACK;
          end
        end
        ST_WSETUP: begin
          sram_nwe_o <= 1'b0;
          state      <= ST_WR;
        end
        ST_WR: begin
          if (ws_zero) begin
            sram_nwe_o <= 1'b1;
            ACK_O      <= CYC_I;
            state      <= ST_WHOLD;
          end
        end
        ST_WHOLD: begin
          sram_ncs_o <= 1'b1;
          state      <= ST_IDLE;
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        ST_ERR: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
